// File: rtl/car_pkg.sv
// Shared car-mode definitions: the cs mode codes consumed by the buzzer and motor
// stages, plus the ultrasonic ranging FSM states and counter widths.
package car_pkg;

  localparam logic [2:0] CS_CLEAR = 3'b001;
  localparam logic [2:0] CS_ALARM = 3'b010;
  localparam logic [2:0] CS_FAULT = 3'b100;

  localparam int CNT_W = 22;
  localparam int SUB_W = 12;
  localparam int CM_W  = 9;

  localparam logic [CM_W-1:0] CM_MAX = 9'd511;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TRIG,
    ST_WAIT_RISE,
    ST_MEASURE,
    ST_DONE,
    ST_FAIL
  } us_state_t;

  function automatic logic [CM_W-1:0] cm_inc_sat(input logic [CM_W-1:0] v);
    return (v == CM_MAX) ? v : v + 9'd1;
  endfunction

endpackage

// File: rtl/ultrasonic_mode_sync_edge.sv
// Two-flop synchronizer for an asynchronous input with single-cycle rise/fall
// pulses derived from the synchronized level.
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_rise = r_sync & ~r_prev;
  assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/ultrasonic_mode.sv
// HC-SR04 style ranging FSM: periodic trigger, echo width to cm conversion, and
// the clear/alarm/fault mode word with near/far hysteresis and fault counting.
module ultrasonic_mode
  import car_pkg::*;
#(
  parameter int TRIG_CYCLES    = 500,
  parameter int PERIOD_CYCLES  = 3_000_000,
  parameter int TIMEOUT_CYCLES = 1_500_000,
  parameter int CYCLES_PER_CM  = 2941,
  parameter int NEAR_CM        = 20,
  parameter int HYST_CM        = 5,
  parameter int FAULT_N        = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            echo,
  output logic            trig,
  output logic [2:0]      cs,
  output logic [CM_W-1:0] dist_cm,
  output logic            dist_valid
);

  localparam int FW = $clog2(FAULT_N + 1);

  localparam logic [CNT_W-1:0] PERIOD_LAST  = CNT_W'(PERIOD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TRIG_LAST    = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [SUB_W-1:0] SUB_LAST     = SUB_W'(CYCLES_PER_CM - 1);
  localparam logic [CM_W-1:0]  NEAR_TH      = CM_W'(NEAR_CM);
  localparam logic [CM_W-1:0]  FAR_TH       = CM_W'(NEAR_CM + HYST_CM);
  localparam logic [FW-1:0]    FAULT_MAX    = FW'(FAULT_N);

  us_state_t        r_state;
  us_state_t        w_state_nx;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_cnt;
  logic [SUB_W-1:0] r_sub;
  logic [CM_W-1:0]  r_cm;
  logic [CM_W-1:0]  r_dist;
  logic             r_trig;
  logic             r_dv;
  logic [2:0]       r_cs;
  logic [2:0]       w_cs_nx;
  logic [1:0]       r_near;
  logic [1:0]       r_far;
  logic [1:0]       w_near_nx;
  logic [1:0]       w_far_nx;
  logic [FW-1:0]    r_fault;
  logic [FW-1:0]    w_fault_nx;
  logic             w_rise;
  logic             w_fall;
  logic             w_is_near;
  logic             w_is_far;

  sync_edge u_sync_edge (
    .clk     (clk),
    .rst     (rst),
    .i_async (echo),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  // Echo already high when WAIT_RISE is entered produces no rise pulse, so a
  // fresh edge is required without any extra qualification.
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_IDLE:      if (r_period == '0) w_state_nx = ST_TRIG;
      ST_TRIG:      if (r_cnt == TRIG_LAST) w_state_nx = ST_WAIT_RISE;
      ST_WAIT_RISE: begin
        if (w_rise)                     w_state_nx = ST_MEASURE;
        else if (r_cnt == TIMEOUT_LAST) w_state_nx = ST_FAIL;
      end
      ST_MEASURE: begin
        if (w_fall)                     w_state_nx = ST_DONE;
        else if (r_cnt == TIMEOUT_LAST) w_state_nx = ST_FAIL;
      end
      ST_DONE:      w_state_nx = ST_IDLE;
      ST_FAIL:      w_state_nx = ST_IDLE;
      default:      w_state_nx = ST_IDLE;
    endcase
  end

  assign w_is_near = (r_cm < NEAR_TH);
  assign w_is_far  = (r_cm >= FAR_TH);

  always_comb begin
    w_cs_nx    = r_cs;
    w_near_nx  = r_near;
    w_far_nx   = r_far;
    w_fault_nx = r_fault;
    if (r_state == ST_DONE) begin
      w_fault_nx = '0;
      if (r_cs == CS_FAULT) begin
        w_cs_nx   = w_is_near ? CS_ALARM : CS_CLEAR;
        w_near_nx = 2'd0;
        w_far_nx  = 2'd0;
      end else if (w_is_near) begin
        w_near_nx = (r_near == 2'd2) ? 2'd2 : r_near + 2'd1;
        w_far_nx  = 2'd0;
        if ((r_cs == CS_CLEAR) && (w_near_nx == 2'd2)) w_cs_nx = CS_ALARM;
      end else if (w_is_far) begin
        w_far_nx  = (r_far == 2'd2) ? 2'd2 : r_far + 2'd1;
        w_near_nx = 2'd0;
        if ((r_cs == CS_ALARM) && (w_far_nx == 2'd2)) w_cs_nx = CS_CLEAR;
      end else begin
        w_near_nx = 2'd0;
        w_far_nx  = 2'd0;
      end
    end else if (r_state == ST_FAIL) begin
      w_fault_nx = (r_fault == FAULT_MAX) ? r_fault : r_fault + 1'b1;
      w_near_nx  = 2'd0;
      w_far_nx   = 2'd0;
      if (w_fault_nx == FAULT_MAX) w_cs_nx = CS_FAULT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_period <= '0;
      r_cnt    <= '0;
      r_sub    <= '0;
      r_cm     <= '0;
      r_dist   <= '0;
      r_trig   <= 1'b0;
      r_dv     <= 1'b0;
      r_cs     <= CS_CLEAR;
      r_near   <= 2'd0;
      r_far    <= 2'd0;
      r_fault  <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_period <= (r_period == PERIOD_LAST) ? '0 : r_period + 22'd1;
      // Per-state cycle counter restarts on every state change.
      if ((w_state_nx != r_state) || (r_state == ST_IDLE)) r_cnt <= '0;
      else                                                 r_cnt <= r_cnt + 22'd1;
      if (r_state == ST_MEASURE) begin
        if (r_sub == SUB_LAST) begin
          r_sub <= '0;
          r_cm  <= cm_inc_sat(r_cm);
        end else begin
          r_sub <= r_sub + 12'd1;
        end
      end else if (r_state == ST_IDLE) begin
        r_sub <= '0;
        r_cm  <= '0;
      end
      r_trig <= (w_state_nx == ST_TRIG);
      r_dv   <= (r_state == ST_DONE);
      if (r_state == ST_DONE) r_dist <= r_cm;
      r_cs    <= w_cs_nx;
      r_near  <= w_near_nx;
      r_far   <= w_far_nx;
      r_fault <= w_fault_nx;
    end
  end

  assign trig       = r_trig;
  assign cs         = r_cs;
  assign dist_cm    = r_dist;
  assign dist_valid = r_dv;

endmodule
